life_window_gen: RTL
====================

# life_window_gen

Streaming neighbourhood generator that feeds the `life` cell. It accepts one grid of `GRID_W` x `GRID_H` single-bit cells in raster order (row-major, row 0 first) and emits, for every cell and in the same order, that cell's state plus its eight neighbours. Cells outside the grid read as 0 (dead). A bit-serial line buffer and a small FSM perform the buffering, while valid/ready handshakes on both sides provide backpressure.

## Interface
- `GRID_W`, 16: cells per row; legal range is 2 or more.
- `GRID_H`, 16: rows per frame; legal range is 2 or more.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_cell` is valid.
- `in_ready`  out  1  block accepts `in_cell` this cycle.
- `in_cell`  in  1  next cell of the frame, in raster order.
- `out_valid`  out  1  window outputs are valid.
- `out_ready`  in  1  consumer accepts the window.
- `out_self`  out  1  centre cell.
- `out_neighbors`  out  8  bit 0 NW, 1 N, 2 NE, 3 W, 4 E, 5 SW, 6 S, 7 SE.
- `out_row`  out  clog2(`GRID_H`)  row of the centre cell.
- `out_col`  out  clog2(`GRID_W`)  column of the centre cell.
- `out_last`  out  1  window is the final cell (`GRID_H`-1, `GRID_W`-1).

## Operation
- Storage is a shift register `sr` of length 2·`GRID_W`+3.
  - On each advance, the new bit enters `sr[0]` and older bits shift up one position.
  - The window centre is `sr[W+1]`.
  - Neighbour taps: NW `sr[2W+2]`, N `sr[2W+1]`, NE `sr[2W]`, W `sr[W+2]`, E `sr[W]`, SW `sr[2]`, S `sr[1]`, SE `sr[0]`.
  - Taps are sampled after the shift.
- Edge masking is applied using the output position:
  - row 0 clears NW, N, NE;
  - row `GRID_H`-1 clears SW, S, SE;
  - column 0 clears NW, W, SW;
  - column `GRID_W`-1 clears NE, E, SE.
- FSM states: `FILL`, `RUN`, `FLUSH`.
  - **`FILL`**: `in_ready`=1. Each accepted cell advances `sr` and produces no window. After `GRID_W`+1 accepted cells, go to `RUN`.
  - **`RUN`**: `in_ready` = !`out_valid` | `out_ready`. Each accepted cell advances `sr` and loads a window into the output register. Once the cell with input index `GRID_W`·`GRID_H`-1 is accepted, go to `FLUSH`.
  - **`FLUSH`**: `in_ready`=0. While !`out_valid` | `out_ready`, a 0 is shifted in internally and a window is loaded. After `GRID_W`+1 flush windows, go to `FILL`.
- Output register rules:
  - It holds its value while `out_valid` & !`out_ready`.
  - `out_valid` clears when the consumer takes the window and no new window loads in the same cycle.
- Counters:
  - input index wraps at `GRID_W`·`GRID_H`;
  - `out_col` wraps at `GRID_W`, and `out_row` increments on that wrap;
  - both output counters reset to 0 after `out_last` is accepted.
- Back-to-back frames: `FILL` of the next frame may run while the final flush window is still held. Leftover `sr` bits are harmless because edge masking hides every stale tap.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state `FILL`, `sr` all 0, all counters 0;
  - `out_valid`=0, `out_self`=0, `out_neighbors`=0, `out_row`=0, `out_col`=0, `out_last`=0;
  - `in_ready`=1 in the cycle after reset.
  - Reset mid-frame discards all partial state; the next accepted cell is cell (0,0).
- The window for cell k appears (registered) in the cycle after cell k+`GRID_W`+1 is accepted. The last `GRID_W`+1 windows of a frame instead come from `FLUSH`.
- Throughput is one window per cycle in steady state.
- Per frame: the stall-free cost is `GRID_W`·`GRID_H` input cycles plus `GRID_W`+1 flush cycles.
- Backpressure: a simultaneous input accept and output accept in `RUN` is legal. No window is ever dropped or duplicated.

## Structure
- Package `life_pkg` holds:
  - neighbour bit-index localparams (`NB_NW` … `NB_SE`);
  - the FSM state enum (`FILL`, `RUN`, `FLUSH`).
- Natural sub-module: `life_line_buffer`. It contains the `sr` shift register with an advance enable and exposes the nine taps. The FSM, counters, masking and output register live in `life_window_gen`.
- The output bundle maps directly onto `life`: `out_self` connects to `self`, and `out_neighbors` connects to `neighbors`.

## Test plan
- **Reset and idle.** Assert `rst_n`=0 for 2 cycles with `in_valid`=0 → `out_valid`=0 and `in_ready`=1; all outputs are 0.
- **All-ones frame, `GRID_W`=`GRID_H`=4, `out_ready`=1.** Expected windows:
  - (0,0) → `out_neighbors`=8'b1101_0000;
  - (1,1) → 8'hFF;
  - (3,3) → 8'b0000_1011, `out_last`=1;
  - exactly 16 windows in total.
- **Blinker, 5x5, vertical bar at (1,2),(2,2),(3,2).**
  - (2,1) → `out_self`=0, popcount(`out_neighbors`)=3;
  - (2,2) → `out_self`=1, popcount 2.
- **Random `out_ready` (50%) and random `in_valid` gaps on a random 8x6 frame.** Window stream matches the reference model bit-exactly, with no drops or duplicates.
- **Two back-to-back frames with `in_valid` held high.** The second frame's row-0 windows contain no bits from frame 1.
- **`rst_n`=0 asserted after 10 cells of a 4x4 frame.** The next 16 inputs are treated as a fresh frame, and the first window is (0,0).

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the life neighbourhood generator: neighbour bit
// positions, the window FSM state type and the edge-mask helper.
package life_pkg;

    // Bit positions of the eight neighbours inside the neighbour bus.
    localparam int unsigned NB_NW = 0;
    localparam int unsigned NB_N  = 1;
    localparam int unsigned NB_NE = 2;
    localparam int unsigned NB_W  = 3;
    localparam int unsigned NB_E  = 4;
    localparam int unsigned NB_SW = 5;
    localparam int unsigned NB_S  = 6;
    localparam int unsigned NB_SE = 7;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } life_state_e;

    // Keep-mask for the neighbour bus: a neighbour that falls outside the
    // grid is forced to 0, which also hides stale line-buffer contents.
    function automatic logic [7:0] edge_mask(input logic top_row,
                                             input logic bot_row,
                                             input logic left_col,
                                             input logic right_col);
        logic [7:0] m;
        m = 8'hFF;
        if (top_row) begin
            m[NB_NW] = 1'b0;
            m[NB_N]  = 1'b0;
            m[NB_NE] = 1'b0;
        end
        if (bot_row) begin
            m[NB_SW] = 1'b0;
            m[NB_S]  = 1'b0;
            m[NB_SE] = 1'b0;
        end
        if (left_col) begin
            m[NB_NW] = 1'b0;
            m[NB_W]  = 1'b0;
            m[NB_SW] = 1'b0;
        end
        if (right_col) begin
            m[NB_NE] = 1'b0;
            m[NB_E]  = 1'b0;
            m[NB_SE] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/life_line_buffer.sv
// Bit-serial line buffer: two grid rows plus three cells of history. The
// taps are taken from the post-advance value so a window can be registered
// in the same cycle the centre's south-east neighbour arrives.
module life_line_buffer
#(
    parameter int GRID_W = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       in_bit,
    output logic       tap_self,
    output logic [7:0] tap_nb
);
    import life_pkg::*;

    localparam int SR_LEN = 2 * GRID_W + 3;

    logic [SR_LEN-1:0] sr_q;
    logic [SR_LEN-1:0] sr_d;

    // Shift a new bit into position 0 when advancing, otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (advance) begin
            sr_d = {sr_q[SR_LEN-2:0], in_bit};
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= {SR_LEN{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    // Nine window taps relative to the centre at W+1.
    always_comb begin
        tap_nb        = 8'h00;
        tap_self      = sr_d[GRID_W + 1];
        tap_nb[NB_NW] = sr_d[2 * GRID_W + 2];
        tap_nb[NB_N]  = sr_d[2 * GRID_W + 1];
        tap_nb[NB_NE] = sr_d[2 * GRID_W];
        tap_nb[NB_W]  = sr_d[GRID_W + 2];
        tap_nb[NB_E]  = sr_d[GRID_W];
        tap_nb[NB_SW] = sr_d[2];
        tap_nb[NB_S]  = sr_d[1];
        tap_nb[NB_SE] = sr_d[0];
    end

endmodule

// File: rtl/life_window_gen.sv
// Streaming 3x3 neighbourhood generator. Cells arrive in raster order; each
// cell's state and its eight (edge-masked) neighbours leave in the same order
// through a registered valid/ready output stage.
module life_window_gen
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_cell,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_self,
    output logic [7:0]                out_neighbors,
    output logic [$clog2(GRID_H)-1:0] out_row,
    output logic [$clog2(GRID_W)-1:0] out_col,
    output logic                      out_last
);
    import life_pkg::*;

    localparam int RW  = $clog2(GRID_H);
    localparam int CW  = $clog2(GRID_W);
    localparam int IW  = $clog2(GRID_W * GRID_H);
    localparam int FCW = $clog2(GRID_W + 1);

    localparam logic [IW-1:0]  IDX_FILL_END = IW'(GRID_W);
    localparam logic [IW-1:0]  IDX_LAST     = IW'(GRID_W * GRID_H - 1);
    localparam logic [FCW-1:0] FLUSH_LAST   = FCW'(GRID_W);
    localparam logic [RW-1:0]  ROW_LAST     = RW'(GRID_H - 1);
    localparam logic [CW-1:0]  COL_LAST     = CW'(GRID_W - 1);

    life_state_e      state_q, state_d;
    logic [IW-1:0]    in_idx_q, in_idx_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]    pos_row_q, pos_row_d;
    logic [CW-1:0]    pos_col_q, pos_col_d;
    logic             out_valid_q, out_valid_d;
    logic             out_self_q, out_self_d;
    logic [7:0]       out_nb_q, out_nb_d;
    logic [RW-1:0]    out_row_q, out_row_d;
    logic [CW-1:0]    out_col_q, out_col_d;
    logic             out_last_q, out_last_d;

    logic             out_free_s;
    logic             in_ready_s;
    logic             adv_s;
    logic             adv_bit_s;
    logic             load_s;
    logic             tap_self_s;
    logic [7:0]       tap_nb_s;
    logic [7:0]       win_nb_s;

    life_line_buffer #(
        .GRID_W (GRID_W)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (adv_s),
        .in_bit   (adv_bit_s),
        .tap_self (tap_self_s),
        .tap_nb   (tap_nb_s)
    );

    assign out_free_s = !out_valid_q || out_ready;

    // FSM next state: decides when the buffer advances and a window loads.
    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        flush_cnt_d = flush_cnt_q;
        in_ready_s  = 1'b0;
        adv_s       = 1'b0;
        adv_bit_s   = 1'b0;
        load_s      = 1'b0;
        case (state_q)
            FILL: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    adv_s     = 1'b1;
                    adv_bit_s = in_cell;
                    in_idx_d  = in_idx_q + IW'(1);
                    if (in_idx_q == IDX_FILL_END) begin
                        state_d = RUN;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                in_ready_s = out_free_s;
                if (in_valid && out_free_s) begin
                    adv_s     = 1'b1;
                    adv_bit_s = in_cell;
                    load_s    = 1'b1;
                    if (in_idx_q == IDX_LAST) begin
                        in_idx_d    = {IW{1'b0}};
                        flush_cnt_d = {FCW{1'b0}};
                        state_d     = FLUSH;
                    end else begin
                        in_idx_d = in_idx_q + IW'(1);
                        state_d  = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // Zeros pushed here become the row below the last grid row,
                // which the bottom-edge mask hides anyway.
                if (out_free_s) begin
                    adv_s  = 1'b1;
                    load_s = 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        flush_cnt_d = {FCW{1'b0}};
                        state_d     = FILL;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FCW'(1);
                        state_d     = FLUSH;
                    end
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d     = FILL;
                in_idx_d    = {IW{1'b0}};
                flush_cnt_d = {FCW{1'b0}};
            end
        endcase
    end

    // Masked window for the position about to be loaded.
    always_comb begin
        win_nb_s = tap_nb_s & edge_mask(pos_row_q == {RW{1'b0}},
                                        pos_row_q == ROW_LAST,
                                        pos_col_q == {CW{1'b0}},
                                        pos_col_q == COL_LAST);
    end

    // Output register and raster position counters.
    always_comb begin
        out_valid_d = out_valid_q;
        out_self_d  = out_self_q;
        out_nb_d    = out_nb_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        pos_row_d   = pos_row_q;
        pos_col_d   = pos_col_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_self_d  = tap_self_s;
            out_nb_d    = win_nb_s;
            out_row_d   = pos_row_q;
            out_col_d   = pos_col_q;
            out_last_d  = (pos_row_q == ROW_LAST) && (pos_col_q == COL_LAST);
            if (pos_col_q == COL_LAST) begin
                pos_col_d = {CW{1'b0}};
                if (pos_row_q == ROW_LAST) begin
                    pos_row_d = {RW{1'b0}};
                end else begin
                    pos_row_d = pos_row_q + RW'(1);
                end
            end else begin
                pos_col_d = pos_col_q + CW'(1);
                pos_row_d = pos_row_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, counter and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            in_idx_q    <= {IW{1'b0}};
            flush_cnt_q <= {FCW{1'b0}};
            pos_row_q   <= {RW{1'b0}};
            pos_col_q   <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            out_self_q  <= 1'b0;
            out_nb_q    <= 8'h00;
            out_row_q   <= {RW{1'b0}};
            out_col_q   <= {CW{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_idx_q    <= in_idx_d;
            flush_cnt_q <= flush_cnt_d;
            pos_row_q   <= pos_row_d;
            pos_col_q   <= pos_col_d;
            out_valid_q <= out_valid_d;
            out_self_q  <= out_self_d;
            out_nb_q    <= out_nb_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_q;
    assign out_self      = out_self_q;
    assign out_neighbors = out_nb_q;
    assign out_row       = out_row_q;
    assign out_col       = out_col_q;
    assign out_last      = out_last_q;

endmodule
